pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the core. It holds G independently updatable field groups through a 2-entry skid buffer, so upstream ready is fully registered. It supports a pipeline flush and a saturating stall counter. It replaces hand-written per-stage registers (decode→execute, execute→memory) that use separate clock-enabled groups. Per-beat group enables are carried with the data instead of separate gated clocks.

## Interface
Parameters:
- G, 4: number of field groups.
- GW, 32: width of each group in bits.
- CW, 16: stall counter width.

Ports:
- clk  in  1  stage clock; all state updates on its rising edge.
- s_reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  G*GW  payload; group g occupies bits [g*GW +: GW].
- in_grp_en  in  G  per-beat group update mask, travels with the beat.
- out_valid  out  1  output register holds a live beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  G*GW  registered payload.
- flush  in  1  kill all live beats in the stage.
- clr_stall  in  1  clear the stall counter.
- stall_cnt  out  CW  saturating count of backpressure cycles.

## Operation
- Storage has two entries. The output entry drives out_valid and out_data. The skid entry holds skid_valid, skid_data and skid_en.
- An in-transfer occurs when in_valid && in_ready. An out-transfer occurs when out_valid && out_ready.
- in_ready = !skid_valid && !flush. The skid term is registered; flush is the only combinational path to in_ready.
- Loading the output entry from a source beat (data D, mask E): for each g, out_data group g <= D group g if E[g]=1, else it keeps its current value. out_valid <= 1.
- The following rules apply with flush=0. Precedence is top to bottom; the first matching rule applies.
  - skid_valid=1 and out_ready=1: load the output from the skid entry; skid_valid <= 0.
  - skid_valid=1 and out_ready=0: hold both entries.
  - skid_valid=0, in-transfer, and (!out_valid || out_ready): load the output from in_data/in_grp_en.
  - skid_valid=0, in-transfer, and out_valid && !out_ready: skid_data <= in_data, skid_en <= in_grp_en, skid_valid <= 1. The output entry holds.
  - skid_valid=0, no in-transfer, and out-transfer: out_valid <= 0. out_data holds.
- flush=1: out_valid <= 0 and skid_valid <= 0. Any beat presented that cycle is not accepted, because in_ready=0. out_data and skid_data are not modified.
- Stall counter:
  - stall_cnt increments when out_valid && !out_ready, evaluated on pre-update state, including a cycle in which flush=1.
  - It saturates at 2^CW−1.
  - clr_stall=1 sets it to 0 and has priority over increment.
- Reset (s_reset_n=0): out_valid, skid_valid, out_data, skid_data, skid_en and stall_cnt are all 0. Reset has priority over flush, clr_stall and handshakes. in_ready=1 in the first cycle after reset is released, provided flush=0.
- A beat with in_grp_en=0 is a valid beat that carries no new data. It still consumes a slot and asserts out_valid.
- Beats are never duplicated, dropped (except by flush) or reordered.

## Timing
- Latency is 1 cycle: a beat accepted at edge k appears on out_valid/out_data after edge k, if the skid entry is empty and the output is free.
- Throughput is 1 beat/cycle with out_ready held high.
- When out_ready falls, at most one more beat is accepted (into skid). in_ready drops the cycle after skid fills.
- When out_ready rises with skid full, the skid beat is presented the next cycle and in_ready rises the next cycle.
- flush affects in_ready in the same cycle and out_valid after the edge. With flush held for multiple cycles, the stage stays empty.

## Test plan
- Streaming: G=4, out_ready=1, send data 0x1..0x8 in each group with grp_en=4'hF → out_data matches each beat exactly 1 cycle later, no gaps, stall_cnt=0.
- Group masking: beat A=all groups 0xAAAAAAAA, mask F; then beat B=0x55555555, mask 4'b0101 → out_data groups {3,2,1,0} = {AAAAAAAA, 55555555, AAAAAAAA, 55555555}.
- Backpressure: hold out_ready=0 while streaming → exactly 2 beats are accepted, in_ready=0 from the cycle after the 2nd. Release out_ready → beats emerge in order. stall_cnt equals the number of cycles with out_valid=1 && out_ready=0.
- Flush with skid full: assert flush for 1 cycle → in_ready=0 that cycle, out_valid=0 and in_ready=1 next cycle, out_data unchanged, no stale beat emerges afterwards.
- Counter saturation/clear: CW=4, hold backpressure for 20 cycles → stall_cnt=15. Assert clr_stall together with backpressure → stall_cnt=0 next cycle.
- Reset mid-operation: skid full and stall_cnt=7, pull s_reset_n low for 1 cycle → all outputs zero after the edge. in_ready=1 after release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Handshaked pipeline stage register. It holds G field groups and uses a
//   two-entry buffer: an output entry and a skid entry. Because of the skid
//   entry, in_ready depends only on registered state, with flush as the one
//   combinational term. Each beat carries a per-group update mask
//   (in_grp_en). When a beat is loaded into the output entry, only its
//   enabled groups overwrite out_data. The other groups keep the values
//   left by earlier beats.
//
// Ports
//   clk        stage clock, rising edge
//   s_reset_n  synchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat
//   in_data    payload, group g at [g*GW +: GW]
//   in_grp_en  per-beat group update mask
//   out_valid  output entry holds a live beat
//   out_ready  downstream accepts the beat
//   out_data   registered payload
//   flush      drop every live beat in the stage
//   clr_stall  clear the stall counter
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg #(
  parameter int G  = 4,
  parameter int GW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            s_reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [G*GW-1:0] in_data,
  input  logic [G-1:0]    in_grp_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [G*GW-1:0] out_data,
  input  logic            flush,
  input  logic            clr_stall,
  output logic [CW-1:0]   stall_cnt
);

  logic            skid_valid;
  logic [G*GW-1:0] skid_data;
  logic [G-1:0]    skid_en;

  // Candidate next out_data for either source. Disabled groups keep the
  // value already in the output entry.
  logic [G*GW-1:0] merge_skid;
  logic [G*GW-1:0] merge_in;

  logic in_xfer;

  assign in_ready = !skid_valid && !flush;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    merge_skid = out_data;
    merge_in   = out_data;
    for (int g = 0; g < G; g++) begin
      if (skid_en[g])   merge_skid[g*GW +: GW] = skid_data[g*GW +: GW];
      if (in_grp_en[g]) merge_in[g*GW +: GW]   = in_data[g*GW +: GW];
    end
  end

  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_en    <= '0;
      stall_cnt  <= '0;
    end else begin
      // The stall counter uses pre-update state. It keeps counting in a
      // flush cycle, so a flush does not hide backpressure.
      if (clr_stall)
        stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != {CW{1'b1}}))
        stall_cnt <= stall_cnt + CW'(1);

      if (flush) begin
        // Only the valid bits are cleared. The data registers keep their
        // contents.
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (skid_valid) begin
        if (out_ready) begin
          out_data   <= merge_skid;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        if (!out_valid || out_ready) begin
          out_data  <= merge_in;
          out_valid <= 1'b1;
        end else begin
          // Output is stalled, so this one extra beat waits in skid.
          skid_data  <= in_data;
          skid_en    <= in_grp_en;
          skid_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int G  = 4;
  localparam int GW = 32;
  localparam int CW = 4;
  localparam int DW = G * GW;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          s_reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [G-1:0]  in_grp_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic          clr_stall;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.G(G), .GW(GW), .CW(CW)) dut (
    .clk       (clk),
    .s_reset_n (s_reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_grp_en (in_grp_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .clr_stall (clr_stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model. It tracks the accepted beats that are still in the
  // stage as an ordered queue; the front beat is the one being presented.
  // The presented word is every presented beat's enabled groups laid over
  // the previous word.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [G-1:0]  e;
  } beat_t;

  beat_t         m_q[$];
  logic [DW-1:0] m_out;
  int            m_stall;

  function automatic logic [DW-1:0] overlay(input logic [DW-1:0] base, input beat_t b);
    logic [DW-1:0] r;
    r = base;
    for (int g = 0; g < G; g++)
      if (b.e[g]) r[g*GW +: GW] = b.d[g*GW +: GW];
    return r;
  endfunction

  function automatic logic [DW-1:0] rep4(input logic [31:0] w);
    return {w, w, w, w};
  endfunction

  // Advances one clock and moves the model by the same edge. Inputs are
  // stable here because they change only just after the falling edge.
  task automatic tick();
    bit    was_empty;
    bit    popped;
    bit    acc;
    beat_t nb;
    beat_t tmp;
    @(posedge clk);
    if (!s_reset_n) begin
      m_q.delete();
      m_out   = '0;
      m_stall = 0;
    end else begin
      was_empty = (m_q.size() == 0);
      popped    = 0;
      acc       = in_valid && (m_q.size() < 2) && !flush;
      if (clr_stall) m_stall = 0;
      else if (m_q.size() > 0 && !out_ready && m_stall < SMAX) m_stall++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (m_q.size() > 0 && out_ready) begin
          tmp    = m_q.pop_front();
          popped = 1;
        end
        if (acc) begin
          nb.d = in_data;
          nb.e = in_grp_en;
          m_q.push_back(nb);
        end
        if ((popped || was_empty) && m_q.size() > 0) m_out = overlay(m_out, m_q[0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_grp_en = '0;
    flush     = 1'b0;
    clr_stall = 1'b0;
  endtask

  task automatic test_reset();
    s_reset_n = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    tick();
    tick();
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++;
    if (stall_cnt !== '0) begin bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    s_reset_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_grp_en = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      in_data = rep4(k[31:0]);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== rep4(k[31:0]))
      begin bad++; $display("FAIL stream_beat[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, rep4(k[31:0])); end
    end
    idle_inputs();
    tick();
    total++;
    if (out_valid !== 1'b0 || stall_cnt !== '0)
    begin bad++; $display("FAIL stream_end: got v=%b stall=%0d want v=0 stall=0", out_valid, stall_cnt); end
  endtask

  task automatic test_masking();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = rep4(32'hAAAA_AAAA);
    in_grp_en = 4'hF;
    tick();
    in_data   = rep4(32'h5555_5555);
    in_grp_en = 4'b0101;
    tick();
    idle_inputs();
    #1;
    total++;
    if (out_data !== {32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555})
    begin bad++; $display("FAIL mask_merge: got %h want aaaaaaaa55555555aaaaaaaa55555555", out_data); end
    tick();
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    acc_cnt   = 0;
    clr_stall = 1'b1;
    tick();
    clr_stall = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_grp_en = 4'hF;
    for (int i = 0; i < 6; i++) begin
      in_data = rep4(32'h100 + i);
      #1;
      total++;
      if (in_ready !== (i < 2)) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want %b", i, in_ready, (i < 2)); end
      if (in_ready) acc_cnt++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (acc_cnt != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", acc_cnt); end
    total++;
    if (stall_cnt !== CW'(5) || m_stall != 5)
    begin bad++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== rep4(32'h100 + i))
      begin bad++; $display("FAIL bp_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, rep4(32'h100 + i)); end
      tick();
      #1;
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_grp_en = 4'hF;
    in_data   = rep4(32'hC0C0_0000);
    tick();
    in_data   = rep4(32'hC1C1_0001);
    tick();
    in_data   = rep4(32'hC2C2_0002);
    flush     = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready_same: got %b want 0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
    begin bad++; $display("FAIL flush_after: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    total++;
    if (out_data !== rep4(32'hC0C0_0000))
    begin bad++; $display("FAIL flush_data: got %h want %h", out_data, rep4(32'hC0C0_0000)); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_saturation();
    clr_stall = 1'b1;
    tick();
    clr_stall = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_grp_en = 4'hF;
    in_data   = rep4(32'h5A7_0000);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (stall_cnt !== CW'(SMAX) || m_stall != SMAX)
    begin bad++; $display("FAIL sat_value: got %0d want %0d", stall_cnt, SMAX); end
    clr_stall = 1'b1;
    tick();
    clr_stall = 1'b0;
    total++;
    if (stall_cnt !== '0) begin bad++; $display("FAIL sat_clear: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    // A beat is already held under backpressure. One more beat fills skid.
    out_ready = 1'b0;
    clr_stall = 1'b1;
    tick();
    clr_stall = 1'b0;
    in_valid  = 1'b1;
    in_data   = rep4(32'hBEEF_0007);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #1;
    total++;
    if (stall_cnt !== CW'(7) || in_ready !== 1'b0)
    begin bad++; $display("FAIL rstmid_setup: got stall=%0d rdy=%b want stall=7 rdy=0", stall_cnt, in_ready); end
    s_reset_n = 1'b0;
    tick();
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || stall_cnt !== '0)
    begin bad++; $display("FAIL rstmid_zero: got v=%b d=%h stall=%0d want all 0", out_valid, out_data, stall_cnt); end
    s_reset_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_dat;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(19) == 0);
      clr_stall = ($urandom_range(24) == 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_grp_en = G'($urandom);
      #1;
      e_rdy = (m_q.size() < 2) && !flush;
      e_vld = (m_q.size() > 0);
      e_dat = m_out;
      total++;
      if (in_ready !== e_rdy) begin bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, e_rdy); end
      total++;
      if (out_valid !== e_vld) begin bad++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_valid, e_vld); end
      total++;
      if (out_data !== e_dat) begin bad++; $display("FAIL rnd_out_data[%0d]: got %h want %h", c, out_data, e_dat); end
      total++;
      if (stall_cnt !== CW'(m_stall)) begin bad++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", c, stall_cnt, m_stall); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_masking();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
